// File: rtl/serial_mode_pkg.sv
`default_nettype none
// ============================================================================
// serial_mode_pkg : shared state encoding and default widths for the sequencer
// Rev 1.0
// ============================================================================
package serial_mode_pkg;

    localparam int DEFAULT_ADDR_W     = 8;
    localparam int DEFAULT_DATA_W     = 8;
    localparam int DEFAULT_DIM_W      = 4;
    localparam int DEFAULT_RES_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/window_addr_gen.sv
`default_nettype none
// ============================================================================
// window_addr_gen : column/row walk of the output window, feature base address
// Rev 1.0
// ============================================================================
module window_addr_gen
    import serial_mode_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DIM_W  = DEFAULT_DIM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [ADDR_W-1:0] i_origin,
    input  logic [ADDR_W-1:0] i_stride,
    input  logic [DIM_W-1:0]  i_out_w,
    input  logic [DIM_W-1:0]  i_out_h,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [DIM_W-1:0]  r_col;
    logic [DIM_W-1:0]  r_row;
    logic [DIM_W-1:0]  r_out_w;
    logic [DIM_W-1:0]  r_out_h;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_addr;

    logic              w_col_end;
    logic [ADDR_W-1:0] w_next_row_base;

    assign w_col_end       = (r_col == (r_out_w - DIM_W'(1)));
    assign w_next_row_base = r_row_base + r_stride;

    // Address arithmetic wraps naturally at the register width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_out_w    <= '0;
            r_out_h    <= '0;
            r_stride   <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
        end else if (i_load) begin
            r_col      <= '0;
            r_row      <= '0;
            r_out_w    <= i_out_w;
            r_out_h    <= i_out_h;
            r_stride   <= i_stride;
            r_row_base <= i_origin;
            r_addr     <= i_origin;
        end else if (i_advance) begin
            if (!w_col_end) begin
                r_col  <= r_col + DIM_W'(1);
                r_addr <= r_addr + ADDR_W'(1);
            end else begin
                r_col      <= '0;
                r_row      <= r_row + DIM_W'(1);
                r_row_base <= w_next_row_base;
                r_addr     <= w_next_row_base;
            end
        end
    end

    assign o_addr = r_addr;
    assign o_last = w_col_end && (r_row == (r_out_h - DIM_W'(1)));

endmodule
`default_nettype wire

// File: rtl/serial_mode_sequencer.sv
`default_nettype none
// ============================================================================
// serial_mode_sequencer : sweeps window positions, drives core, stores results
// Rev 1.0
// ============================================================================
module serial_mode_sequencer
    import serial_mode_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int DIM_W      = DEFAULT_DIM_W,
    parameter int RES_ADDR_W = DEFAULT_RES_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     origin_i,
    input  logic [ADDR_W-1:0]     stride_i,
    input  logic [DIM_W-1:0]      out_w_i,
    input  logic [DIM_W-1:0]      out_h_i,
    output logic                  core_en_o,
    output logic [ADDR_W-1:0]     feature_baseaddr_o,
    input  logic                  core_done_i,
    input  logic [DATA_W-1:0]     core_out_i,
    output logic                  res_we_o,
    output logic [RES_ADDR_W-1:0] res_addr_o,
    output logic [DATA_W-1:0]     res_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_load;
    logic                  w_advance;
    logic                  w_last;
    logic                  w_zero_dim;
    logic [RES_ADDR_W-1:0] r_idx;
    logic                  r_res_we;
    logic [RES_ADDR_W-1:0] r_res_addr;
    logic [DATA_W-1:0]     r_res_data;

    assign w_load     = (r_state == ST_IDLE) && start_i;
    assign w_advance  = (r_state == ST_RUN) && core_done_i;
    assign w_zero_dim = (out_w_i == '0) || (out_h_i == '0);

    window_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_advance (w_advance),
        .i_origin  (origin_i),
        .i_stride  (stride_i),
        .i_out_w   (out_w_i),
        .i_out_h   (out_h_i),
        .o_addr    (feature_baseaddr_o),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start_i) w_next_state = w_zero_dim ? ST_FINISH : ST_RUN;
            ST_RUN:    if (core_done_i && w_last) w_next_state = ST_FINISH;
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        core_en_o = (r_state == ST_RUN);
        busy_o    = (r_state != ST_IDLE);
        done_o    = (r_state == ST_FINISH);
    end

    // Result written one cycle after the core's done, at the pre-increment index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_res_we   <= 1'b0;
            r_res_addr <= '0;
            r_res_data <= '0;
        end else begin
            r_res_we <= w_advance;
            if (w_load) begin
                r_idx <= '0;
            end else if (w_advance) begin
                r_idx      <= r_idx + RES_ADDR_W'(1);
                r_res_addr <= r_idx;
                r_res_data <= core_out_i;
            end
        end
    end

    assign res_we_o   = r_res_we;
    assign res_addr_o = r_res_addr;
    assign res_data_o = r_res_data;

endmodule
`default_nettype wire

// File: tb/tb_serial_mode_sequencer.sv
`default_nettype none
// ============================================================================
// tb_serial_mode_sequencer : randomized sweeps checked against a window model
// Rev 1.0
// ============================================================================
module tb_serial_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] origin_i = '0;
    logic [7:0] stride_i = '0;
    logic [3:0] out_w_i = '0;
    logic [3:0] out_h_i = '0;
    logic       core_en_o;
    logic [7:0] feature_baseaddr_o;
    logic       core_done_i = 1'b0;
    logic [7:0] core_out_i = '0;
    logic       res_we_o;
    logic [7:0] res_addr_o;
    logic [7:0] res_data_o;
    logic       busy_o;
    logic       done_o;

    int n_tests = 0;
    int n_fail  = 0;

    serial_mode_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .start_i            (start_i),
        .origin_i           (origin_i),
        .stride_i           (stride_i),
        .out_w_i            (out_w_i),
        .out_h_i            (out_h_i),
        .core_en_o          (core_en_o),
        .feature_baseaddr_o (feature_baseaddr_o),
        .core_done_i        (core_done_i),
        .core_out_i         (core_out_i),
        .res_we_o           (res_we_o),
        .res_addr_o         (res_addr_o),
        .res_data_o         (res_data_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: position list of the sweep --------
    int         m_mode = 0;   // 0 idle, 1 sweeping, 2 finishing
    int         m_p, m_n, m_w;
    logic [7:0] m_o, m_s;
    logic       m_we, m_rst_seen;
    logic [7:0] m_wa, m_wd;

    function automatic logic [7:0] pos_addr(input int p);
        return 8'(int'(m_o) + (p / m_w) * int'(m_s) + (p % m_w));
    endfunction

    always @(posedge clk) begin
        m_rst_seen = rst;
        m_we = 1'b0;
        if (rst) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (start_i) begin
                    m_o = origin_i; m_s = stride_i; m_w = int'(out_w_i);
                    m_n = int'(out_w_i) * int'(out_h_i);
                    m_p = 0;
                    m_mode = (m_n == 0) ? 2 : 1;
                end
                1: if (core_done_i) begin
                    m_we = 1'b1; m_wa = 8'(m_p); m_wd = core_out_i;
                    m_p++;
                    if (m_p == m_n) m_mode = 2;
                end
                default: m_mode = 0;
            endcase
        end
        #1;
        check("core_en", core_en_o, m_mode == 1);
        check("busy", busy_o, m_mode != 0);
        check("done", done_o, m_mode == 2);
        check("res_we", res_we_o, m_we);
        if (m_mode == 1) check("feature_addr", feature_baseaddr_o, pos_addr(m_p));
        if (m_we) begin
            check("res_addr", res_addr_o, m_wa);
            check("res_data", res_data_o, m_wd);
        end
        if (m_rst_seen) begin
            check("rst_feature", feature_baseaddr_o, 0);
            check("rst_res_addr", res_addr_o, 0);
            check("rst_res_data", res_data_o, 0);
        end
    end

    // ---------------- core model with random latency ------------------------
    int   lat_lo = 1, lat_hi = 4, lat_cnt = 0;
    logic spurious_req = 1'b0;

    always @(negedge clk) begin
        core_done_i = 1'b0;
        if (spurious_req) begin
            core_done_i = 1'b1;
            core_out_i  = 8'($urandom);
        end else if (core_en_o && !rst) begin
            if (lat_cnt == 0) begin
                lat_cnt = $urandom_range(lat_hi, lat_lo);
            end else begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    core_done_i = 1'b1;
                    core_out_i  = 8'($urandom);
                end
            end
        end else begin
            lat_cnt = 0;
        end
    end

    // ---------------- observation recorder ----------------------------------
    logic [7:0] seen_addr_q[$];
    logic [7:0] seen_out_q[$];
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         done_cnt = 0;
    int         en_cnt = 0;

    always @(negedge clk) begin
        #1;
        if (core_done_i && core_en_o) begin
            seen_addr_q.push_back(feature_baseaddr_o);
            seen_out_q.push_back(core_out_i);
        end
        if (res_we_o) begin
            wr_addr_q.push_back(res_addr_o);
            wr_data_q.push_back(res_data_o);
        end
        if (done_o) done_cnt++;
        if (core_en_o) en_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_obs();
        seen_addr_q.delete(); seen_out_q.delete();
        wr_addr_q.delete(); wr_data_q.delete();
        done_cnt = 0; en_cnt = 0;
    endtask

    task automatic launch(input logic [7:0] o, input logic [7:0] s, input logic [3:0] w, input logic [3:0] h);
        step();
        origin_i = o; stride_i = s; out_w_i = w; out_h_i = h; start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cnt == 0 && k < 3000) begin
            step();
            k++;
        end
        check("sweep_timeout", done_cnt > 0, 1);
        repeat (3) step();
    endtask

    task automatic run_sweep(input logic [7:0] o, input logic [7:0] s, input logic [3:0] w,
                             input logic [3:0] h, input int lo, input int hi);
        lat_lo = lo; lat_hi = hi;
        clear_obs();
        launch(o, s, w, h);
        wait_done();
    endtask

    logic [7:0] exp_t1[4] = '{8'd9, 8'd10, 8'd13, 8'd14};
    logic [7:0] exp_t4[6] = '{8'd250, 8'd251, 8'd252, 8'd254, 8'd255, 8'd0};

    initial begin
        repeat (10) step();
        rst = 1'b0;
        step();

        // Basic 2x2 sweep
        run_sweep(8'd9, 8'd4, 4'd2, 4'd2, 1, 4);
        check("t1_positions", seen_addr_q.size(), 4);
        check("t1_writes", wr_addr_q.size(), 4);
        for (int i = 0; i < 4 && i < seen_addr_q.size(); i++)
            check("t1_addr_seq", seen_addr_q[i], exp_t1[i]);
        for (int i = 0; i < 4 && i < wr_addr_q.size() && i < seen_out_q.size(); i++) begin
            check("t1_wr_addr", wr_addr_q[i], i);
            check("t1_wr_data", wr_data_q[i], seen_out_q[i]);
        end
        check("t1_done_pulses", done_cnt, 1);

        // Long variable latency
        run_sweep(8'd40, 8'd7, 4'd3, 4'd2, 3, 20);
        check("t2_writes", wr_addr_q.size(), 6);
        check("t2_done_pulses", done_cnt, 1);

        // Zero dimension: done right after accept, no core activity
        clear_obs();
        step();
        origin_i = 8'd5; out_w_i = 4'd0; out_h_i = 4'd3; start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("t3_done_next", done_o, 1);
        check("t3_no_en", core_en_o, 0);
        repeat (4) step();
        check("t3_done_pulses", done_cnt, 1);
        check("t3_en_cycles", en_cnt, 0);
        check("t3_writes", wr_addr_q.size(), 0);
        run_sweep(8'd5, 8'd1, 4'd3, 4'd0, 1, 2);
        check("t3b_en_cycles", en_cnt, 0);
        check("t3b_writes", wr_addr_q.size(), 0);

        // Address wrap
        run_sweep(8'd250, 8'd4, 4'd3, 4'd2, 1, 3);
        check("t4_positions", seen_addr_q.size(), 6);
        for (int i = 0; i < 6 && i < seen_addr_q.size(); i++)
            check("t4_addr_seq", seen_addr_q[i], exp_t4[i]);
        for (int i = 0; i < 6 && i < wr_addr_q.size(); i++)
            check("t4_wr_addr", wr_addr_q[i], i);

        // Reset mid-sweep after second write
        lat_lo = 2; lat_hi = 5;
        clear_obs();
        launch(8'd20, 8'd8, 4'd2, 4'd2);
        for (int k = 0; k < 500 && wr_addr_q.size() < 2; k++) step();
        check("t5_two_writes", wr_addr_q.size(), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (20) step();
        check("t5_no_more_writes", wr_addr_q.size(), 2);
        check("t5_no_done", done_cnt, 0);
        run_sweep(8'd20, 8'd8, 4'd2, 4'd2, 1, 3);
        check("t5_restart_first_addr", seen_addr_q.size() > 0 ? seen_addr_q[0] : 8'hxx, 8'd20);
        check("t5_restart_idx", wr_addr_q.size() > 0 ? wr_addr_q[0] : 8'hxx, 8'd0);

        // Spurious done in IDLE, start re-pulsed mid-sweep
        clear_obs();
        step();
        spurious_req = 1'b1;
        step();
        spurious_req = 1'b0;
        repeat (2) step();
        check("t6_spurious_no_write", wr_addr_q.size(), 0);
        lat_lo = 2; lat_hi = 6;
        launch(8'd100, 8'd10, 4'd2, 4'd3);
        repeat (5) step();
        origin_i = 8'd33; stride_i = 8'd1; out_w_i = 4'd1; out_h_i = 4'd1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_done();
        check("t6_writes", wr_addr_q.size(), 6);
        check("t6_done_pulses", done_cnt, 1);
        check("t6_last_addr", seen_addr_q.size() == 6 ? seen_addr_q[5] : 8'hxx, 8'd121);

        // Randomized sweeps
        for (int n = 0; n < 10; n++) begin
            logic [3:0] w, h;
            w = 4'($urandom_range(4, 0));
            h = 4'($urandom_range(4, 0));
            run_sweep(8'($urandom), 8'($urandom), w, h, 1, 6);
            check("rand_writes", wr_addr_q.size(), int'(w) * int'(h));
            check("rand_done_pulses", done_cnt, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
